// File: rtl/volume_ctrl.sv
// ----------------------------------------------------------------------------
// volume_ctrl
//
// Saturating volume level with mute and a smoothed amplitude output. Sits
// directly after the button conditioning stage and runs in the div_15 domain.
//
// Ports:
//   clk        in   1        block clock (div_15 at the top level)
//   rst        in   1        synchronous, active-high reset
//   volUP      in   1        one-cycle request to raise the level
//   volDOWN    in   1        one-cycle request to lower the level
//   mute       in   1        one-cycle request to toggle mute
//   level      out  LEVEL_W  current volume level (registered)
//   muted      out  1        current mute state (registered)
//   amp        out  AMP_W    amplitude scale, ramps toward target (registered)
//   ramping    out  1        amp differs from target (combinational)
//   limit_hit  out  1        one-cycle pulse for a press at a level boundary
// ----------------------------------------------------------------------------
module volume_ctrl #(
    parameter int               LEVEL_W    = 3,
    parameter int               LEVEL_MAX  = 5,
    parameter int               LEVEL_INIT = 3,
    parameter int               AMP_W      = 16,
    parameter logic [AMP_W-1:0] AMP_STEP   = 16'h1000,
    parameter logic [AMP_W-1:0] RAMP_INC   = 16'h0400,
    parameter int               RAMP_DIV   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               volUP,
    input  logic               volDOWN,
    input  logic               mute,
    output logic [LEVEL_W-1:0] level,
    output logic               muted,
    output logic [AMP_W-1:0]   amp,
    output logic               ramping,
    output logic               limit_hit
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_INIT = LEVEL_W'(LEVEL_INIT);
    localparam logic [AMP_W-1:0]   AMP_INIT = AMP_W'(LEVEL_INIT * AMP_STEP);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RAMP_DIV - 1);
    // Ramp arithmetic is one bit wider than the amplitude word.
    localparam logic [AMP_W:0]     STEP_X   = {1'b0, AMP_STEP};
    localparam logic [AMP_W:0]     INC_X    = {1'b0, RAMP_INC};

    logic [LEVEL_W-1:0] level_q, level_d;
    logic               muted_q, muted_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [CNT_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic               limit_q, limit_d;

    logic [AMP_W:0] target_x;
    logic [AMP_W:0] amp_x;
    logic [AMP_W:0] diff_x;
    logic [AMP_W:0] step_x;
    logic [AMP_W:0] amp_next_x;
    logic           unused_amp_msb;

    // Target and distance to it, from registered state only.
    always_comb begin
        target_x = muted_q ? '0 : ((AMP_W+1)'(level_q) * STEP_X);
        amp_x    = {1'b0, amp_q};
        diff_x   = (target_x >= amp_x) ? (target_x - amp_x) : (amp_x - target_x);
        // Clamping the step to the remaining distance prevents overshoot.
        step_x   = (diff_x > INC_X) ? INC_X : diff_x;
        amp_next_x = (target_x > amp_x) ? (amp_x + step_x) : (amp_x - step_x);
    end

    // The step never overshoots, so the result always fits in AMP_W bits.
    assign unused_amp_msb = amp_next_x[AMP_W];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        level_d    = level_q;
        muted_d    = muted_q ^ mute;
        limit_d    = 1'b0;
        amp_d      = amp_q;
        ramp_cnt_d = ramp_cnt_q;

        // Simultaneous up and down cancel each other, including at limits.
        if (volUP && !volDOWN) begin
            if (level_q == LVL_MAX) limit_d = 1'b1;
            else                    level_d = level_q + LEVEL_W'(1);
        end else if (volDOWN && !volUP) begin
            if (level_q == '0)      limit_d = 1'b1;
            else                    level_d = level_q - LEVEL_W'(1);
        end

        // A target change mid-ramp keeps the counter phase.
        if (amp_x == target_x) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q != CNT_LAST) begin
            ramp_cnt_d = ramp_cnt_q + CNT_W'(1);
        end else begin
            ramp_cnt_d = '0;
            amp_d      = amp_next_x[AMP_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= LVL_INIT;
            muted_q    <= 1'b0;
            amp_q      <= AMP_INIT;
            ramp_cnt_q <= '0;
            limit_q    <= 1'b0;
        end else begin
            level_q    <= level_d;
            muted_q    <= muted_d;
            amp_q      <= amp_d;
            ramp_cnt_q <= ramp_cnt_d;
            limit_q    <= limit_d;
        end
    end

    assign level     = level_q;
    assign muted     = muted_q;
    assign amp       = amp_q;
    assign limit_hit = limit_q;
    assign ramping   = (amp_x != target_x);

endmodule

// File: tb/tb_volume_ctrl.sv
// ----------------------------------------------------------------------------
// tb_volume_ctrl
//
// Self-checking bench for volume_ctrl at default parameters: a vector table
// of single-cycle steps, hand-written ramp/mute/reset sequences, and a
// randomized run compared against a cycle model built from the level, mute
// and ramp rules.
// ----------------------------------------------------------------------------
module tb_volume_ctrl;

    localparam int LEVEL_MAX  = 5;
    localparam int LEVEL_INIT = 3;
    localparam int AMP_STEP   = 'h1000;
    localparam int RAMP_INC   = 'h0400;
    localparam int RAMP_DIV   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        volUP = 1'b0;
    logic        volDOWN = 1'b0;
    logic        mute = 1'b0;
    logic [2:0]  level;
    logic        muted;
    logic [15:0] amp;
    logic        ramping;
    logic        limit_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    volume_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .volUP     (volUP),
        .volDOWN   (volDOWN),
        .mute      (mute),
        .level     (level),
        .muted     (muted),
        .amp       (amp),
        .ramping   (ramping),
        .limit_hit (limit_hit)
    );

    // Reference model: plain integers stepped once per rising edge.
    int m_level = LEVEL_INIT;
    int m_muted = 0;
    int m_amp   = LEVEL_INIT * AMP_STEP;
    int m_cnt   = 0;
    int m_lim   = 0;

    function automatic int m_target();
        return (m_muted != 0) ? 0 : m_level * AMP_STEP;
    endfunction

    task automatic model_step(input bit up, input bit dn, input bit mu, input bit rs);
        int tgt;
        int delta;
        if (rs) begin
            m_level = LEVEL_INIT;
            m_muted = 0;
            m_amp   = LEVEL_INIT * AMP_STEP;
            m_cnt   = 0;
            m_lim   = 0;
            return;
        end
        tgt = m_target();
        if (m_amp == tgt) begin
            m_cnt = 0;
        end else if (m_cnt < RAMP_DIV - 1) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            delta = tgt - m_amp;
            if (delta >  RAMP_INC) delta =  RAMP_INC;
            if (delta < -RAMP_INC) delta = -RAMP_INC;
            m_amp += delta;
        end
        m_lim = 0;
        if (up && !dn) begin
            if (m_level == LEVEL_MAX) m_lim = 1;
            else                      m_level++;
        end else if (dn && !up) begin
            if (m_level == 0) m_lim = 1;
            else              m_level--;
        end
        if (mu) m_muted = 1 - m_muted;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, lets the DUT and model take the edge, and
    // returns 1 time unit after the edge with inputs cleared.
    task automatic cycle(input bit up, input bit dn, input bit mu, input bit rs);
        volUP = up; volDOWN = dn; mute = mu; rst = rs;
        @(posedge clk);
        model_step(up, dn, mu, rs);
        #1;
        volUP = 1'b0; volDOWN = 1'b0; mute = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"},     int'(level),     m_level);
        check({tag, ".muted"},     int'(muted),     m_muted);
        check({tag, ".amp"},       int'(amp),       m_amp);
        check({tag, ".ramping"},   int'(ramping),   int'(m_amp != m_target()));
        check({tag, ".limit_hit"}, int'(limit_hit), m_lim);
    endtask

    typedef struct {
        bit up, dn, mu, rs;
        int lvl, mtd, amp, rmp, lim;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit up, input bit dn, input bit mu, input bit rs,
                                input int lvl, input int mtd, input int a,
                                input int rmp, input int lim);
        vec_t v;
        v.up = up; v.dn = dn; v.mu = mu; v.rs = rs;
        v.lvl = lvl; v.mtd = mtd; v.amp = a; v.rmp = rmp; v.lim = lim;
        tbl.push_back(v);
    endfunction

    initial begin
        //  up dn mu rs   lvl mtd amp     rmp lim
        add(0, 0, 0, 1,   3,  0,  'h3000, 0,  0);  // reset, two cycles
        add(0, 0, 0, 1,   3,  0,  'h3000, 0,  0);
        add(1, 1, 0, 0,   3,  0,  'h3000, 0,  0);  // up+down ignored
        add(0, 1, 0, 0,   2,  0,  'h3000, 1,  0);
        add(1, 0, 0, 0,   3,  0,  'h3000, 0,  0);  // target restored before a step
        add(0, 0, 1, 0,   3,  1,  'h3000, 1,  0);  // mute
        add(1, 0, 1, 0,   4,  0,  'h3000, 1,  0);  // unmute and up together
        add(0, 0, 0, 1,   3,  0,  'h3000, 0,  0);
        add(1, 0, 0, 0,   4,  0,  'h3000, 1,  0);  // saturate upward
        add(1, 0, 0, 0,   5,  0,  'h3000, 1,  0);
        add(1, 0, 0, 0,   5,  0,  'h3000, 1,  1);
        add(1, 0, 0, 0,   5,  0,  'h3000, 1,  1);  // back-to-back limit
        add(0, 0, 0, 0,   5,  0,  'h3400, 1,  0);  // first step, limit drops
        add(0, 0, 0, 1,   3,  0,  'h3000, 0,  0);
        add(0, 1, 0, 0,   2,  0,  'h3000, 1,  0);  // saturate downward
        add(0, 1, 0, 0,   1,  0,  'h3000, 1,  0);
        add(0, 1, 0, 0,   0,  0,  'h3000, 1,  0);
        add(0, 1, 0, 0,   0,  0,  'h3000, 1,  1);
        add(1, 1, 0, 0,   0,  0,  'h2C00, 1,  0);  // no limit on up+down at 0
        add(0, 0, 0, 1,   3,  0,  'h3000, 0,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].up, tbl[i].dn, tbl[i].mu, tbl[i].rs);
            check($sformatf("vec%0d.level", i),     int'(level),     tbl[i].lvl);
            check($sformatf("vec%0d.muted", i),     int'(muted),     tbl[i].mtd);
            check($sformatf("vec%0d.amp", i),       int'(amp),       tbl[i].amp);
            check($sformatf("vec%0d.ramping", i),   int'(ramping),   tbl[i].rmp);
            check($sformatf("vec%0d.limit_hit", i), int'(limit_hit), tbl[i].lim);
        end

        // One volUP: step timing and end of ramp.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("up.level", int'(level), 4);
        check("up.ramping_start", int'(ramping), 1);
        idle(3);  check("up.amp+3",  int'(amp), 'h3000);
        idle(1);  check("up.amp+4",  int'(amp), 'h3400);
        idle(4);  check("up.amp+8",  int'(amp), 'h3800);
        idle(4);  check("up.amp+12", int'(amp), 'h3C00);
        idle(3);  check("up.ramping+15", int'(ramping), 1);
        idle(1);  check("up.amp+16", int'(amp), 'h4000);
        check("up.ramping+16", int'(ramping), 0);

        // Mute ramp down, level change while muted, unmute ramp up.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        check("mute.muted", int'(muted), 1);
        idle(47); check("mute.amp+47", int'(amp), 'h0400);
        check("mute.ramping+47", int'(ramping), 1);
        idle(1);  check("mute.amp+48", int'(amp), 0);
        check("mute.ramping+48", int'(ramping), 0);
        cycle(1, 0, 0, 0);
        check("mute.up_level", int'(level), 4);
        check("mute.up_ramping", int'(ramping), 0);
        idle(19); check("mute.up_amp", int'(amp), 0);
        cycle(0, 0, 1, 0);
        check("unmute.muted", int'(muted), 0);
        idle(63); check("unmute.amp+63", int'(amp), 'h3C00);
        idle(1);  check("unmute.amp+64", int'(amp), 'h4000);
        check("unmute.ramping+64", int'(ramping), 0);

        // Reset mid-ramp, then no ramp out of reset.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        idle(5);  check("rstmid.amp_before", int'(amp), 'h3400);
        cycle(0, 0, 0, 1);
        check("rstmid.amp", int'(amp), 'h3000);
        check("rstmid.level", int'(level), 3);
        check("rstmid.ramping", int'(ramping), 0);
        idle(10); check("rstmid.amp_hold", int'(amp), 'h3000);
        check_model("rstmid");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 499) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
